// File: rtl/dbus_uart_tx_pkg.sv
// Shared register map, bit positions and FSM encodings for the memory-mapped UART transmitter.
// UART_TX_PARITY_EN adds the PARITY state (8E1 framing).
package dbus_uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 8;

    localparam int CTRL_TX_EN   = 0;
    localparam int CTRL_OVF_CLR = 1;
    localparam int CTRL_IRQ_EN  = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/dbus_uart_tx_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    // Fullness uses the pre-edge count, so a same-cycle pop never rescues a push.
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dbus_uart_tx.sv
// Data-bus UART transmitter: register decode, TX FIFO, frame FSM with baud counter.
// Define UART_TX_PARITY_EN for an even parity bit after the data bits.
module dbus_uart_tx
    import dbus_uart_tx_pkg::*;
#(
    parameter int CLK_DIV    = 108,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        txd,
    output logic        irq,
    output tx_state_e   dbg_state_o
);

    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);

    tx_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        txd_q, txd_d;
    logic        irq_q, tx_en_q, irq_en_q, ovf_q;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    logic        fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic        wr_en, txdata_wr, ctrl_wr, busy, baud_done;
    logic        unused_bits;

    assign wr_en     = ce & we & sel[0];
    assign txdata_wr = wr_en & (addr[3:2] == REG_TXDATA);
    assign ctrl_wr   = wr_en & (addr[3:2] == REG_CTRL);
    assign busy      = (state_q != S_IDLE);
    assign baud_done = (baud_q == '0);
    assign unused_bits = ^{addr[31:4], addr[1:0], sel[3:1], data_i[31:8], data_i[7:3]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (txdata_wr),
        .pop   (fifo_pop),
        .din   (data_i[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_done ? '0 : baud_q - 1'b1;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (tx_en_q && !fifo_empty) begin
                    state_d  = S_START;
                    baud_d   = BAUD_RELOAD;
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_dout;
`endif
                end
            end
            S_START: begin
                if (baud_done) begin
                    state_d   = S_DATA;
                    baud_d    = BAUD_RELOAD;
                    bit_idx_d = 3'd0;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_done) begin
                    state_d = S_STOP;
                    baud_d  = BAUD_RELOAD;
                end
            end
`endif
            S_STOP: begin
                // Chain straight into the next START so queued bytes leave with no idle gap.
                if (baud_done) begin
                    if (tx_en_q && !fifo_empty) begin
                        state_d  = S_START;
                        baud_d   = BAUD_RELOAD;
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^fifo_dout;
`endif
                    end else begin
                        state_d = S_IDLE;
                        baud_d  = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase

        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = parity_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
            irq_q     <= 1'b0;
            tx_en_q   <= 1'b1;
            irq_en_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
            irq_q     <= irq_en_q & fifo_empty & ~busy;
            if (ctrl_wr) begin
                tx_en_q  <= data_i[CTRL_TX_EN];
                irq_en_q <= data_i[CTRL_IRQ_EN];
            end
            if (txdata_wr && fifo_full) begin
                ovf_q <= 1'b1;
            end else if (ctrl_wr && data_i[CTRL_OVF_CLR]) begin
                ovf_q <= 1'b0;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) parity_q <= 1'b0;
        else     parity_q <= parity_d;
    end
`endif

    always_comb begin
        data_o = '0;
        if (ce && !we) begin
            case (addr[3:2])
                REG_STATUS: begin
                    data_o[ST_FULL]               = fifo_full;
                    data_o[ST_EMPTY]              = fifo_empty;
                    data_o[ST_BUSY]               = busy;
                    data_o[ST_OVF]                = ovf_q;
                    data_o[ST_COUNT_LSB +: 8]     = 8'(fifo_count);
                end
                REG_CTRL: begin
                    data_o[CTRL_TX_EN]  = tx_en_q;
                    data_o[CTRL_IRQ_EN] = irq_en_q;
                end
                default: data_o = '0;
            endcase
        end
    end

    assign txd         = txd_q;
    assign irq         = irq_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dbus_uart_tx.sv
// Directed bench for dbus_uart_tx: register access, framing, FIFO overflow, back-to-back and reset abort.
// Builds with or without UART_TX_PARITY_EN; the parity scenario runs only when it is defined.
module tb_dbus_uart_tx;
    import dbus_uart_tx_pkg::*;

    localparam int CLK_DIV    = 108;
    localparam int FIFO_DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk, rst, ce, we;
    logic [31:0] addr, data_i, data_o;
    logic [3:0]  sel;
    logic        txd, irq;
    tx_state_e   dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    dbus_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .we          (we),
        .addr        (addr),
        .sel         (sel),
        .data_i      (data_i),
        .data_o      (data_o),
        .txd         (txd),
        .irq         (irq),
        .dbg_state_o (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Driver tasks (called on a negedge, return on the following negedge)
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        ce = 1'b1; we = 1'b1; addr = a; data_i = d; sel = s;
        @(negedge clk);
        ce = 1'b0; we = 1'b0; addr = '0; data_i = '0; sel = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        ce = 1'b1; we = 1'b0; addr = a;
        #1;
        d = data_o;
        ce = 1'b0; addr = '0;
    endtask

    // Records the level of each bit and whether txd moved inside its CLK_DIV window.
    task automatic capture_bits(input int first, input int last,
                                output logic [10:0] seen, output logic [10:0] glitch);
        seen = '0;
        glitch = '0;
        for (int i = first; i <= last; i++) begin
            for (int c = 0; c < CLK_DIV; c++) begin
                @(negedge clk);
                if (c == 0) seen[i] = txd;
                else if (txd !== seen[i]) glitch[i] = 1'b1;
            end
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b0, 1'b1, b, 1'b0};
`endif
    endfunction

    task automatic test_reset();
        logic [31:0] rd;
        tests_run++;
        if (txd !== 1'b1) begin tests_failed++; $display("FAIL reset_txd: got %b expected 1", txd); end
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset_irq: got %b expected 0", irq); end
        tests_run++;
        if (dbg_state !== S_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE); end
        bus_read(32'h4, rd);
        tests_run++;
        if (rd !== 32'h0000_0002) begin tests_failed++; $display("FAIL reset_status: got %h expected 00000002", rd); end
        bus_read(32'h8, rd);
        tests_run++;
        if (rd !== 32'h0000_0001) begin tests_failed++; $display("FAIL reset_ctrl: got %h expected 00000001", rd); end
        bus_read(32'h0, rd);
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++; $display("FAIL txdata_reads_zero: got %h expected 00000000", rd); end
    endtask

    task automatic test_ignored_writes();
        logic [31:0] rd;
        bus_write(32'h0, 32'h0000_ABAB, 4'b0010);
        bus_write(32'hC, 32'hFFFF_FFFF, 4'b1111);
        bus_read(32'h4, rd);
        tests_run++;
        if (rd !== 32'h0000_0002) begin tests_failed++; $display("FAIL sel0_clear_no_push: got %h expected 00000002", rd); end
        bus_read(32'hC, rd);
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++; $display("FAIL reserved_reads_zero: got %h expected 00000000", rd); end
        bus_read(32'h8, rd);
        tests_run++;
        if (rd !== 32'h0000_0001) begin tests_failed++; $display("FAIL reserved_write_ignored: got %h expected 00000001", rd); end
        @(negedge clk);
        tests_run++;
        if (txd !== 1'b1) begin tests_failed++; $display("FAIL no_frame_started: got %b expected 1", txd); end
    endtask

    task automatic test_single_frame();
        logic [31:0] rd;
        logic [10:0] seen, glitch, exp;
        bus_write(32'h8, 32'h5, 4'b0001);
        @(negedge clk);
        tests_run++;
        if (irq !== 1'b1) begin tests_failed++; $display("FAIL irq_idle_empty: got %b expected 1", irq); end
        bus_write(32'h0, 32'h55, 4'b0001);
        tests_run++;
        if (txd !== 1'b1) begin tests_failed++; $display("FAIL txd_before_start: got %b expected 1", txd); end
        exp = frame_bits(8'h55);
        capture_bits(0, NBITS-1, seen, glitch);
        tests_run++;
        if (seen !== exp || glitch !== 11'd0)
            begin tests_failed++; $display("FAIL frame_55: got bits %b glitch %b expected %b", seen, glitch, exp); end
        bus_read(32'h4, rd);
        tests_run++;
        if (rd !== 32'h0000_0006) begin tests_failed++; $display("FAIL busy_last_stop_cycle: got %h expected 00000006", rd); end
        @(negedge clk);
        bus_read(32'h4, rd);
        tests_run++;
        if (rd !== 32'h0000_0002) begin tests_failed++; $display("FAIL busy_cleared: got %h expected 00000002", rd); end
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_not_yet: got %b expected 0", irq); end
        @(negedge clk);
        tests_run++;
        if (irq !== 1'b1) begin tests_failed++; $display("FAIL irq_after_stop: got %b expected 1", irq); end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        bus_write(32'h8, 32'h0, 4'b0001);
        ce = 1'b1; we = 1'b1; addr = 32'h0; sel = 4'b0001;
        for (int i = 0; i < 17; i++) begin
            data_i = 32'h10 + 32'(i);
            @(negedge clk);
        end
        ce = 1'b0; we = 1'b0; data_i = '0; sel = '0;
        bus_read(32'h4, rd);
        tests_run++;
        if (rd !== 32'h0000_1009) begin tests_failed++; $display("FAIL overflow_status: got %h expected 00001009", rd); end
        bus_write(32'h8, 32'h2, 4'b0001);
        bus_read(32'h4, rd);
        tests_run++;
        if (rd !== 32'h0000_1001) begin tests_failed++; $display("FAIL ovf_cleared: got %h expected 00001001", rd); end
        bus_read(32'h8, rd);
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++; $display("FAIL ctrl_ovf_clr_reads_zero: got %h expected 00000000", rd); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] rd;
        ce = 1'b1; we = 1'b1; sel = 4'b0001;
        addr = 32'h8; data_i = 32'h1;
        @(negedge clk);
        addr = 32'h0; data_i = 32'hEE;
        @(negedge clk);
        ce = 1'b0; we = 1'b0; addr = '0; data_i = '0; sel = '0;
        bus_read(32'h4, rd);
        tests_run++;
        if (rd !== 32'h0000_0F0C) begin tests_failed++; $display("FAIL full_push_same_pop: got %h expected 00000f0c", rd); end
        tests_run++;
        if (txd !== 1'b0 || dbg_state !== S_START)
            begin tests_failed++; $display("FAIL pop_started_frame: got txd %b state %0d expected 0 %0d", txd, dbg_state, S_START); end
        do_reset();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [10:0] seen, glitch, exp;
        bus_write(32'h8, 32'h0, 4'b0001);
        bus_write(32'h0, 32'hA5, 4'b0001);
        bus_write(32'h0, 32'h3C, 4'b0001);
        bus_read(32'h4, rd);
        tests_run++;
        if (rd !== 32'h0000_0200) begin tests_failed++; $display("FAIL queued_two: got %h expected 00000200", rd); end
        bus_write(32'h8, 32'h1, 4'b0001);
        exp = frame_bits(8'hA5);
        capture_bits(0, NBITS-1, seen, glitch);
        tests_run++;
        if (seen !== exp || glitch !== 11'd0)
            begin tests_failed++; $display("FAIL frame_a5: got bits %b glitch %b expected %b", seen, glitch, exp); end
        exp = frame_bits(8'h3C);
        capture_bits(0, NBITS-1, seen, glitch);
        tests_run++;
        if (seen !== exp || glitch !== 11'd0)
            begin tests_failed++; $display("FAIL frame_3c_no_gap: got bits %b glitch %b expected %b", seen, glitch, exp); end
        bus_read(32'h4, rd);
        tests_run++;
        if (rd !== 32'h0000_0006) begin tests_failed++; $display("FAIL b2b_last_cycle_busy: got %h expected 00000006", rd); end
        @(negedge clk);
        bus_read(32'h4, rd);
        tests_run++;
        if (rd !== 32'h0000_0002 || txd !== 1'b1)
            begin tests_failed++; $display("FAIL b2b_idle_after: got %h txd %b expected 00000002 1", rd, txd); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        logic [10:0] seen, glitch, exp;
        logic        bad;
        do_reset();
        bus_write(32'h0, 32'hF0, 4'b0001);
        exp = frame_bits(8'hF0);
        capture_bits(0, 3, seen, glitch);
        tests_run++;
        if (seen[3:0] !== exp[3:0] || glitch !== 11'd0)
            begin tests_failed++; $display("FAIL f0_first_bits: got %b glitch %b expected %b", seen[3:0], glitch, exp[3:0]); end
        bus_write(32'h0, 32'h0F, 4'b0001);
        bad = (txd !== 1'b0);
        repeat (53) begin
            @(negedge clk);
            if (txd !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin tests_failed++; $display("FAIL f0_bit3_low: got txd %b expected 0", txd); end
        bus_read(32'h4, rd);
        tests_run++;
        if (rd !== 32'h0000_0104) begin tests_failed++; $display("FAIL mid_frame_status: got %h expected 00000104", rd); end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (txd !== 1'b1 || dbg_state !== S_IDLE)
            begin tests_failed++; $display("FAIL abort_txd_state: got %b %0d expected 1 %0d", txd, dbg_state, S_IDLE); end
        bus_read(32'h4, rd);
        tests_run++;
        if (rd !== 32'h0000_0002) begin tests_failed++; $display("FAIL abort_status: got %h expected 00000002", rd); end
        rst = 1'b0;
        @(negedge clk);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [10:0] seen, glitch;
        do_reset();
        bus_write(32'h8, 32'h5, 4'b0001);
        bus_write(32'h0, 32'h07, 4'b0001);
        capture_bits(0, 10, seen, glitch);
        tests_run++;
        if (seen !== 11'b110_0000_1110 || glitch !== 11'd0)
            begin tests_failed++; $display("FAIL parity_frame_07: got bits %b glitch %b expected 11000001110", seen, glitch); end
        @(negedge clk);
        tests_run++;
        if (irq !== 1'b0 || txd !== 1'b1) begin tests_failed++; $display("FAIL parity_irq_early: got irq %b txd %b expected 0 1", irq, txd); end
        @(negedge clk);
        tests_run++;
        if (irq !== 1'b1) begin tests_failed++; $display("FAIL parity_irq_after_stop: got %b expected 1", irq); end
    endtask
`endif

    initial begin
        rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; sel = '0; data_i = '0;
        @(negedge clk);
        do_reset();
        test_reset();
        test_ignored_writes();
        test_single_frame();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
